// File: rtl/params.sv
// Shared constants and the per-stage control word for multiply_add_acc.
package params;
    localparam int INPUT_SIZE = 8;   // default operand width
    localparam int ACC_SIZE   = 24;  // default result/accumulator width

    // Control that travels alongside each pipeline stage's data.
    typedef struct packed {
        logic valid;
        logic mode;   // 0 = pass, 1 = accumulate
        logic last;   // closes an accumulate group
    } stage_ctl_t;
endpackage

// File: rtl/maa_acc_stage.sv
// S3 of multiply_add_acc: output register, group accumulator and sticky
// overflow flag. Define MULTIPLY_ADD_ACC_SATURATE_EN to clamp the accumulator
// on overflow instead of wrapping.
module maa_acc_stage
    import params::*;
#(
    parameter int PROD_W = 17,
    parameter int ACC_W  = 24
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  stage_ctl_t        i_ctl,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_valid,
    output logic              o_ovf
);
    logic [ACC_W-1:0] r_acc;
    logic             r_sticky;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_grp_ovf;
    logic [ACC_W-1:0] w_acc_next;

    assign w_prod_ext = ACC_W'(i_prod);
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
    // Overflow is sticky for the whole group: a carry now or any earlier one.
    assign w_grp_ovf  = r_sticky | w_sum[ACC_W];
`ifdef MULTIPLY_ADD_ACC_SATURATE_EN
    // Once the group has overflowed the accumulator stays pinned at max.
    assign w_acc_next = w_grp_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    // Output register and accumulator; frozen whenever the pipeline stalls.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            o_result <= '0;
            o_valid  <= 1'b0;
            o_ovf    <= 1'b0;
        end else if (i_en) begin
            if (i_ctl.valid && !i_ctl.mode) begin
                // Pass beat: open accumulation is left untouched.
                o_result <= w_prod_ext;
                o_valid  <= 1'b1;
                o_ovf    <= 1'b0;
            end else if (i_ctl.valid && i_ctl.last) begin
                o_result <= w_acc_next;
                o_valid  <= 1'b1;
                o_ovf    <= w_grp_ovf;
                r_acc    <= '0;
                r_sticky <= 1'b0;
            end else if (i_ctl.valid) begin
                r_acc    <= w_acc_next;
                r_sticky <= w_grp_ovf;
                o_valid  <= 1'b0;
            end else begin
                o_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/multiply_add_acc.sv
// (A+B)*C pipeline with pass and group-accumulate modes. Three stages:
// S1 sum+C, S2 product, S3 accumulator/output (maa_acc_stage). A single
// global stall freezes everything while an output result is not taken.
// Build option: MULTIPLY_ADD_ACC_SATURATE_EN (saturating accumulator).
module multiply_add_acc
    import params::*;
#(
    parameter int IN_W  = INPUT_SIZE,
    parameter int ACC_W = ACC_SIZE
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic [IN_W-1:0]  C,
    input  logic             mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             out_ovf
);
    localparam int PROD_W = 2*IN_W + 1;

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("multiply_add_acc: ACC_W must be >= 2*IN_W+1");
    end

    logic              w_stall;
    stage_ctl_t        r_s1_ctl, r_s2_ctl;
    logic [IN_W:0]     r_s1_sum;
    logic [IN_W-1:0]   r_s1_c;
    logic [PROD_W-1:0] r_s2_prod;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    // S1/S2: operand sum then product; bubbles flow through as valid=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_ctl  <= '0;
            r_s1_sum  <= '0;
            r_s1_c    <= '0;
            r_s2_ctl  <= '0;
            r_s2_prod <= '0;
        end else if (!w_stall) begin
            r_s1_ctl  <= '{valid: in_valid, mode: mode, last: in_last};
            r_s1_sum  <= {1'b0, A} + {1'b0, B};
            r_s1_c    <= C;
            r_s2_ctl  <= r_s1_ctl;
            r_s2_prod <= PROD_W'(r_s1_sum) * PROD_W'(r_s1_c);
        end
    end

    maa_acc_stage #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_en      (!w_stall),
        .i_ctl     (r_s2_ctl),
        .i_prod    (r_s2_prod),
        .o_result  (result),
        .o_valid   (out_valid),
        .o_ovf     (out_ovf)
    );
endmodule
